// File: rtl/cbd_sampler_if.sv
// Handshake bundle for cbd_sampler: control, PRF word input and coefficient output.
interface cbd_sampler_if #(
    parameter int DIN_W   = 32,
    parameter int COEFF_W = 12,
    parameter int LANES   = 2
);
    logic                     start;
    logic                     eta_sel;
    logic [DIN_W-1:0]         din;
    logic                     din_valid;
    logic                     din_ready;
    logic [LANES*COEFF_W-1:0] coeff;
    logic                     coeff_valid;
    logic                     coeff_ready;
    logic                     busy;
    logic                     done;

    modport slave (
        input  start, eta_sel, din, din_valid, coeff_ready,
        output din_ready, coeff, coeff_valid, busy, done
    );

    modport master (
        output start, eta_sel, din, din_valid, coeff_ready,
        input  din_ready, coeff, coeff_valid, busy, done
    );
endinterface

// File: rtl/cbd_sampler.sv
// Streaming CBD noise sampler (eta 2/3) for one N-coefficient polynomial per start..done.
// Define CBD_SIGNED_OUT_EN for sign-extended lanes instead of mod-Q reduced lanes.
module cbd_sampler #(
    parameter int DIN_W   = 32,
    parameter int COEFF_W = 12,
    parameter int Q       = 3329,
    parameter int N       = 256,
    parameter int LANES   = 2,
    parameter int BUF_W   = 64
) (
    input logic          clk,
    input logic          rst,
    cbd_sampler_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int OCC_W  = $clog2(BUF_W + 1);
    localparam int WORD_W = $clog2(N * 6 / DIN_W + 1);
    localparam int BEAT_W = $clog2(N / LANES + 1);

    localparam logic [WORD_W-1:0] WORDS_ETA2   = WORD_W'(N * 4 / DIN_W);
    localparam logic [WORD_W-1:0] WORDS_ETA3   = WORD_W'(N * 6 / DIN_W);
    localparam logic [BEAT_W-1:0] LAST_BEAT    = BEAT_W'(N / LANES - 1);
    localparam logic [OCC_W-1:0]  APPEND_LIMIT = OCC_W'(BUF_W - DIN_W);

    logic [1:0]               state;
    logic                     eta3;
    logic [BUF_W-1:0]         bitBuf;
    logic [OCC_W-1:0]         occ;
    logic [WORD_W-1:0]        wordCnt;
    logic [BEAT_W-1:0]        coefCnt;
    logic [LANES*COEFF_W-1:0] coeffReg;
    logic                     coeffValidReg;

    logic [OCC_W-1:0]         beatBits;
    logic [OCC_W-1:0]         occAfter;
    logic [WORD_W-1:0]        wordLimit;
    logic                     appendEn;
    logic                     consumeEn;
    logic                     beatDone;
    logic [BUF_W-1:0]         shifted;
    logic [BUF_W-1:0]         bufNext;
    logic [LANES*COEFF_W-1:0] laneVals;

    function automatic logic [1:0] ones3(input logic [2:0] x);
        return {1'b0, x[0]} + {1'b0, x[1]} + {1'b0, x[2]};
    endfunction

    // Consume happens first so an appended word lands just above whatever bits survive the shift.
    assign beatBits      = eta3 ? OCC_W'(LANES * 6) : OCC_W'(LANES * 4);
    assign wordLimit     = eta3 ? WORDS_ETA3 : WORDS_ETA2;
    assign bus.din_ready = (state == RUN) && (wordCnt < wordLimit) && (occ <= APPEND_LIMIT);
    assign appendEn      = bus.din_valid && bus.din_ready;
    assign consumeEn     = (state == RUN) && (occ >= beatBits) && (!coeffValidReg || bus.coeff_ready);
    assign beatDone      = coeffValidReg && bus.coeff_ready;
    assign shifted       = consumeEn ? (bitBuf >> beatBits) : bitBuf;
    assign occAfter      = consumeEn ? (occ - beatBits) : occ;
    assign bufNext       = appendEn ? (shifted | ({{(BUF_W-DIN_W){1'b0}}, bus.din} << occAfter)) : shifted;

    assign bus.coeff       = coeffReg;
    assign bus.coeff_valid = coeffValidReg;
    assign bus.busy        = (state == RUN);
    assign bus.done        = (state == DONE);

    // Each lane takes 2*eta bits from the buffer bottom; magnitude/sign form keeps the mod-Q step a subtract.
    always_comb begin
        logic [1:0] posSum;
        logic [1:0] negSum;
        logic [1:0] mag;
        logic       neg;
        laneVals = '0;
        posSum   = '0;
        negSum   = '0;
        mag      = '0;
        neg      = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (eta3) begin
                posSum = ones3(bitBuf[k*6 +: 3]);
                negSum = ones3(bitBuf[k*6+3 +: 3]);
            end else begin
                posSum = ones3({1'b0, bitBuf[k*4 +: 2]});
                negSum = ones3({1'b0, bitBuf[k*4+2 +: 2]});
            end
            neg = (posSum < negSum);
            mag = neg ? (negSum - posSum) : (posSum - negSum);
`ifdef CBD_SIGNED_OUT_EN
            laneVals[k*COEFF_W +: COEFF_W] = neg ? (COEFF_W'(0) - COEFF_W'(mag)) : COEFF_W'(mag);
`else
            laneVals[k*COEFF_W +: COEFF_W] = neg ? (COEFF_W'(Q) - COEFF_W'(mag)) : COEFF_W'(mag);
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            eta3          <= 1'b0;
            bitBuf        <= '0;
            occ           <= '0;
            wordCnt       <= '0;
            coefCnt       <= '0;
            coeffReg      <= '0;
            coeffValidReg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state   <= RUN;
                        eta3    <= bus.eta_sel;
                        bitBuf  <= '0;
                        occ     <= '0;
                        wordCnt <= '0;
                        coefCnt <= '0;
                    end
                end
                RUN: begin
                    bitBuf <= bufNext;
                    occ    <= appendEn ? (occAfter + OCC_W'(DIN_W)) : occAfter;
                    if (appendEn) begin
                        wordCnt <= wordCnt + 1'b1;
                    end
                    if (consumeEn) begin
                        coeffReg      <= laneVals;
                        coeffValidReg <= 1'b1;
                    end else if (beatDone) begin
                        coeffValidReg <= 1'b0;
                    end
                    if (beatDone) begin
                        coefCnt <= coefCnt + 1'b1;
                        if (coefCnt == LAST_BEAT) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cbd_sampler.sv
// Randomised self-checking bench for cbd_sampler against a bit-stream reference model.
module tb_cbd_sampler;
    localparam int DIN_W   = 32;
    localparam int COEFF_W = 12;
    localparam int Q       = 3329;
    localparam int N       = 256;
    localparam int LANES   = 2;
    localparam int BEATS   = N / LANES;

`ifdef CBD_SIGNED_OUT_EN
    localparam logic [COEFF_W-1:0] EXP_M2 = 12'hFFE;
    localparam logic [COEFF_W-1:0] EXP_M3 = 12'hFFD;
`else
    localparam logic [COEFF_W-1:0] EXP_M2 = 12'd3327;
    localparam logic [COEFF_W-1:0] EXP_M3 = 12'd3326;
`endif

    logic clk = 1'b0;
    logic rst;
    int   testsRun = 0;
    int   testsFailed = 0;
    logic [31:0] words [0:47];
    logic [LANES*COEFF_W-1:0] firstBeat;

    always #5 clk = ~clk;

    cbd_sampler_if #(.DIN_W(DIN_W), .COEFF_W(COEFF_W), .LANES(LANES)) bus ();

    cbd_sampler #(
        .DIN_W(DIN_W), .COEFF_W(COEFF_W), .Q(Q), .N(N), .LANES(LANES), .BUF_W(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Coefficient idx reads 2*eta consecutive stream bits, word 0 bit 0 first.
    function automatic logic [COEFF_W-1:0] refCoeff(input int idx, input int eta);
        int a = 0;
        int b = 0;
        int base = idx * 2 * eta;
        int v;
        for (int j = 0; j < eta; j++) begin
            a += int'(words[(base + j) / 32][(base + j) % 32]);
            b += int'(words[(base + eta + j) / 32][(base + eta + j) % 32]);
        end
        v = a - b;
`ifdef CBD_SIGNED_OUT_EN
        return COEFF_W'(v);
`else
        return (v < 0) ? COEFF_W'(Q + v) : COEFF_W'(v);
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic es, input logic [31:0] d,
                                 input logic dv, input logic cr);
        bus.start       = st;
        bus.eta_sel     = es;
        bus.din         = d;
        bus.din_valid   = dv;
        bus.coeff_ready = cr;
    endtask

    // One full polynomial; eta_sel is driven inverted throughout RUN and start re-pulsed at glitchCycle.
    task automatic runPoly(input logic eta3, input int readyPct, input int glitchCycle);
        int eta = eta3 ? 3 : 2;
        int numWords = N * 2 * eta / 32;
        int wordIdx = 0;
        int beat = 0;
        int cyc = 0;
        int firstDin = -1;
        int firstValid = -1;
        int lastHs = -1;
        int doneCount = 0;
        int doneCyc = -1;
        logic stalled = 1'b0;
        logic extraChecked = 1'b0;
        logic cr;
        logic [LANES*COEFF_W-1:0] heldCoeff = '0;
        logic [LANES*COEFF_W-1:0] expBeat;

        @(negedge clk);
        applyStimulus(1'b1, eta3, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        while (doneCount == 0 && cyc < 3000) begin
            @(negedge clk);
            cr = ($urandom_range(99) < readyPct);
            applyStimulus(cyc == glitchCycle, ~eta3,
                          (wordIdx < numWords) ? words[wordIdx] : 32'hDEADBEEF, 1'b1, cr);
            #1;
            if (bus.done) begin
                doneCount++;
                doneCyc = cyc;
            end
            if (stalled) begin
                checkOutput("stallHold", 64'({bus.coeff_valid, bus.coeff}), 64'({1'b1, heldCoeff}));
            end
            if (bus.coeff_valid && firstValid < 0) firstValid = cyc;
            if (bus.coeff_valid && cr) begin
                for (int k = 0; k < LANES; k++) begin
                    expBeat[k*COEFF_W +: COEFF_W] = refCoeff(beat * LANES + k, eta);
                end
                checkOutput("beat", 64'(bus.coeff), 64'(expBeat));
                if (beat == 0) firstBeat = bus.coeff;
                beat++;
                lastHs = cyc;
            end
            stalled   = bus.coeff_valid && !cr;
            heldCoeff = bus.coeff;
            if (wordIdx >= numWords) begin
                if (!extraChecked && bus.busy) begin
                    checkOutput("extraWordRefused", 64'(bus.din_ready), 64'(0));
                    extraChecked = 1'b1;
                end
            end else if (bus.din_ready) begin
                if (firstDin < 0) firstDin = cyc;
                wordIdx++;
            end
            cyc++;
        end
        checkOutput("doneSeen", 64'(doneCount), 64'(1));
        checkOutput("beatCount", 64'(beat), 64'(BEATS));
        checkOutput("wordCount", 64'(wordIdx), 64'(numWords));
        checkOutput("doneTiming", 64'(doneCyc), 64'(lastHs + 1));
        checkOutput("firstLatency", 64'(firstValid - firstDin), 64'(2));
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("donePulseEnds", 64'({bus.done, bus.busy}), 64'(0));
    endtask

    initial begin
        int fed;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        checkOutput("resetOutputs",
                    64'({bus.busy, bus.done, bus.coeff_valid, bus.din_ready, bus.coeff}), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 48; i++) words[i] = 32'h0;
        runPoly(1'b0, 100, -1);
        checkOutput("zeroStreamFirst", 64'(firstBeat), 64'(0));

        words[0] = 32'h0000000C;
        runPoly(1'b0, 100, -1);
        checkOutput("eta2FirstBeat", 64'(firstBeat), 64'({12'd0, EXP_M2}));

        words[0] = 32'h00000038;
        runPoly(1'b1, 100, -1);
        checkOutput("eta3FirstBeat", 64'(firstBeat), 64'({12'd0, EXP_M3}));

        for (int i = 0; i < 48; i++) words[i] = $urandom;
        runPoly(1'b1, 50, -1);

        // Abort mid-polynomial: outputs clear immediately and no done follows.
        for (int i = 0; i < 48; i++) words[i] = $urandom;
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        fed = 0;
        for (int c = 0; c < 100 && fed < 10; c++) begin
            @(negedge clk);
            applyStimulus(1'b0, 1'b0, words[fed], 1'b1, 1'b1);
            #1;
            if (bus.din_ready) fed++;
        end
        checkOutput("abortWordsFed", 64'(fed), 64'(10));
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("abortBusyBefore", 64'(bus.busy), 64'(1));
        rst = 1'b1;
        #1;
        checkOutput("abortOutputs",
                    64'({bus.busy, bus.done, bus.coeff_valid, bus.din_ready, bus.coeff}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            checkOutput("abortNoDone", 64'({bus.done, bus.busy}), 64'(0));
        end

        for (int i = 0; i < 48; i++) words[i] = $urandom;
        runPoly(1'b0, 50, 5);
        for (int i = 0; i < 48; i++) words[i] = $urandom;
        runPoly(1'b1, 70, 12);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
